// File: rtl/mask_match_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mask_match_pkg
// Description : Shared FSM state encoding and parameter derivation helpers
//               for the mask match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mask_match_pkg;

  // FSM state encoding: IDLE holds no pair, EMIT has beats outstanding.
  typedef logic [0:0] state_t;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Width of a bit index into a mask of w bits (at least one bit).
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Width able to hold a popcount of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_encoder.sv
`default_nettype none
// ============================================================================
// Module      : lsb_encoder
// Description : Index of the lowest set bit of a vector, plus a flag that is
//               high when exactly one bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_encoder
  import mask_match_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             onehot
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only if there was exactly one.
  assign onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/mask_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mask_match_sequencer
// Description : Accepts a weight/activation bitmask pair and emits one beat
//               per bit position set in both masks, lowest first, with the
//               popcount of each mask below that position. A pair with no
//               common bits yields a single "none" beat.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_match_sequencer
  import mask_match_pkg::*;
#(
  parameter int MASK_WIDTH = 16,
  parameter int IDX_W      = idx_width(MASK_WIDTH),
  parameter int CNT_W      = cnt_width(MASK_WIDTH)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MASK_WIDTH-1:0] bitmaskW,
  input  logic [MASK_WIDTH-1:0] bitmaskA,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [CNT_W-1:0]      out_offsetW,
  output logic [CNT_W-1:0]      out_offsetA,
  output logic                  out_none,
  output logic                  out_last,
  output logic [CNT_W-1:0]      out_countW,
  output logic [CNT_W-1:0]      out_countA
);

  state_t                  state;
  logic [MASK_WIDTH-1:0]   mask_w;
  logic [MASK_WIDTH-1:0]   mask_a;
  logic [MASK_WIDTH-1:0]   remaining;
  logic                    none_flag;

  logic [IDX_W-1:0]        lsb_idx;
  logic                    lsb_onehot;
  logic [MASK_WIDTH-1:0]   below_mask;
  logic                    accept;
  logic                    fire;

  function automatic logic [CNT_W-1:0] popcnt(input logic [MASK_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MASK_WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  lsb_encoder #(
    .WIDTH (MASK_WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb (
    .vec    (remaining),
    .idx    (lsb_idx),
    .onehot (lsb_onehot)
  );

  // Beat outputs are pure functions of the held registers, so they stay
  // stable under backpressure and hold after the last beat is taken.
  assign out_valid   = (state == ST_EMIT);
  assign out_idx     = lsb_idx;
  assign out_none    = none_flag;
  assign out_last    = lsb_onehot | none_flag;
  assign out_countW  = popcnt(mask_w);
  assign out_countA  = popcnt(mask_a);
  assign out_offsetW = popcnt(mask_w & below_mask);
  assign out_offsetA = popcnt(mask_a & below_mask);

  assign fire     = out_valid & out_ready;
  // Accepting on the last beat lets back-to-back pairs run without a bubble;
  // reset gates ready so nothing is taken while it is asserted.
  assign in_ready = ~reset & ((state == ST_IDLE) | (fire & out_last));
  assign accept   = in_valid & in_ready;

  // Thermometer mask of bit positions strictly below the current index.
  always_comb begin
    below_mask = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      below_mask[i] = (i < int'(out_idx));
    end
  end

  // Pair load, per-beat lowest-bit retirement and IDLE/EMIT sequencing.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mask_w    <= '0;
      mask_a    <= '0;
      remaining <= '0;
      none_flag <= 1'b0;
    end else if (accept) begin
      state     <= ST_EMIT;
      mask_w    <= bitmaskW;
      mask_a    <= bitmaskA;
      remaining <= bitmaskW & bitmaskA;
      none_flag <= ((bitmaskW & bitmaskA) == '0);
    end else if (fire) begin
      if (out_last) begin
        // Leave remaining untouched so output data holds its final value.
        state <= ST_IDLE;
      end else begin
        remaining <= remaining & (remaining - MASK_WIDTH'(1));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_match_sequencer
// Description : Directed self-checking bench for mask_match_sequencer at
//               MASK_WIDTH 16 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_match_sequencer;

  logic        clk;
  logic        rst;

  // 16-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, out_none, out_last;
  logic [15:0] bm_w, bm_a;
  logic [3:0]  out_idx;
  logic [4:0]  off_w, off_a, cnt_w, cnt_a;

  // 64-bit instance
  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_none64, out_last64;
  logic [63:0] bm_w64, bm_a64;
  logic [5:0]  out_idx64;
  logic [6:0]  off_w64, off_a64, cnt_w64, cnt_a64;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mask_match_sequencer #(.MASK_WIDTH(16)) u_dut16 (
    .CLOCK_50(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .bitmaskW(bm_w), .bitmaskA(bm_a),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_offsetW(off_w), .out_offsetA(off_a),
    .out_none(out_none), .out_last(out_last),
    .out_countW(cnt_w), .out_countA(cnt_a)
  );

  mask_match_sequencer #(.MASK_WIDTH(64)) u_dut64 (
    .CLOCK_50(clk), .reset(rst),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .bitmaskW(bm_w64), .bitmaskA(bm_a64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_idx(out_idx64), .out_offsetW(off_w64), .out_offsetA(off_a64),
    .out_none(out_none64), .out_last(out_last64),
    .out_countW(cnt_w64), .out_countA(cnt_a64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair to the 16-bit instance and let it be accepted.
  task automatic load16(input logic [15:0] w, input logic [15:0] a);
    bm_w = w; bm_a = a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; bm_w = '0; bm_a = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; bm_w64 = '0; bm_a64 = '0;
    tick(); tick();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_idx",       out_idx,   0);
    check("rst_last",      out_last,  0);
    check("rst_none",      out_none,  0);
    check("rst_count_w",   cnt_w,     0);
    check("rst_in_ready64", in_ready64, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // W=0x00F0 A=0x0FF0: idx 4..7, offsets 0..3, counts 4/8
    load16(16'h00F0, 16'h0FF0);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", out_valid, 1);
      check("t1_idx",   out_idx,   64'(4 + k));
      check("t1_off_w", off_w,     64'(k));
      check("t1_off_a", off_a,     64'(k));
      check("t1_last",  out_last,  (k == 3) ? 1 : 0);
      check("t1_cnt_w", cnt_w,     4);
      check("t1_cnt_a", cnt_a,     8);
      tick();
    end
    check("t1_idle_valid", out_valid, 0);
    check("t1_hold_idx",   out_idx,   7);
    check("t1_idle_ready", in_ready,  1);

    // W=0x00FF A=0xFF00: single none beat
    load16(16'h00FF, 16'hFF00);
    check("t2_valid", out_valid, 1);
    check("t2_none",  out_none,  1);
    check("t2_last",  out_last,  1);
    check("t2_idx",   out_idx,   0);
    check("t2_off_w", off_w,     0);
    check("t2_off_a", off_a,     0);
    check("t2_cnt_w", cnt_w,     8);
    check("t2_cnt_a", cnt_a,     8);
    tick();
    check("t2_done", out_valid, 0);

    // W=A=0xFFFF with out_ready alternating: data stable while stalled
    load16(16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      out_ready = 1'b0;
      #1;
      check("t3_valid",     out_valid, 1);
      check("t3_idx",       out_idx,   64'(k));
      check("t3_off_w",     off_w,     64'(k));
      check("t3_cnt_w",     cnt_w,     16);
      tick();
      check("t3_stall_valid", out_valid, 1);
      check("t3_stall_idx",   out_idx,   64'(k));
      check("t3_stall_off_a", off_a,     64'(k));
      check("t3_stall_last",  out_last,  (k == 15) ? 1 : 0);
      out_ready = 1'b1;
      tick();
    end
    check("t3_done", out_valid, 0);

    // Back-to-back pairs without a bubble
    load16(16'h0001, 16'h0001);
    check("t4_a_idx",  out_idx,  0);
    check("t4_a_last", out_last, 1);
    bm_w = 16'h8000; bm_a = 16'h8000; in_valid = 1'b1;
    #1;
    check("t4_in_ready_on_last", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t4_b_valid", out_valid, 1);
    check("t4_b_idx",   out_idx,   15);
    check("t4_b_off_w", off_w,     0);
    check("t4_b_last",  out_last,  1);
    tick();
    check("t4_done", out_valid, 0);

    // Reset mid-pair after the 2nd of 4 beats
    load16(16'h000F, 16'h000F);
    tick(); tick();
    check("t5_pre_idx", out_idx, 2);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready,  0);
    check("t5_rst_idx",   out_idx,   0);
    check("t5_rst_cnt_w", cnt_w,     0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_post_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_residual", out_valid, 0);
    end

    // 64-bit instance, all-ones
    bm_w64 = '1; bm_a64 = '1; in_valid64 = 1'b1;
    tick();
    in_valid64 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check("t6_valid", out_valid64, 1);
      check("t6_idx",   out_idx64,   64'(k));
      if (k == 63) begin
        check("t6_last_off_w", off_w64,    63);
        check("t6_last_cnt_w", cnt_w64,    64);
        check("t6_last_cnt_a", cnt_a64,    64);
        check("t6_last",       out_last64, 1);
      end
      tick();
    end
    check("t6_done", out_valid64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
